// File: rtl/dds_ctrl_pkg.sv
// dds_ctrl_pkg: command codes, parser FSM states and tuning defaults shared by the DDS control path
package dds_ctrl_pkg;
  localparam logic [7:0] CMD_FWORD1 = 8'h01;
  localparam logic [7:0] CMD_PWORD1 = 8'h02;
  localparam logic [7:0] CMD_FWORD2 = 8'h03;
  localparam logic [7:0] CMD_PWORD2 = 8'h04;
  localparam logic [7:0] CMD_MSEL1  = 8'h05;
  localparam logic [7:0] CMD_MSEL2  = 8'h06;
  localparam logic [31:0] FWORD_RST_DEF = 32'd8589;
  typedef enum logic [1:0] {ST_IDLE, ST_GET_CMD, ST_GET_DATA, ST_GET_CHK} state_e;
  function automatic logic cmd_valid(input logic [7:0] c);
    return c >= CMD_FWORD1 && c <= CMD_MSEL2;
  endfunction
endpackage

// File: rtl/dds_uart_cmd_parser.sv
// dds_uart_cmd_parser: parses 7-byte UART frames (HDR CMD D3 D2 D1 D0 CHK) into DDS tuning registers
//   in : Clk, Reset_n (async, active low), Rx_data[7:0], Rx_done (1-cycle byte strobe)
//   out: Fword1/2[31:0], Pword1/2[11:0], Module_Sel1/2[1:0], Cmd_ok / Cmd_err (1-cycle pulses)
module dds_uart_cmd_parser
  import dds_ctrl_pkg::*;
#(
  parameter logic [7:0]  HEADER      = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 500_000,
  parameter logic [31:0] FWORD_RST   = FWORD_RST_DEF
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [7:0]  Rx_data,
  input  logic        Rx_done,
  output logic [31:0] Fword1,
  output logic [11:0] Pword1,
  output logic [31:0] Fword2,
  output logic [11:0] Pword2,
  output logic [1:0]  Module_Sel1,
  output logic [1:0]  Module_Sel2,
  output logic        Cmd_ok,
  output logic        Cmd_err
);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  state_e state_q, state_d;
  logic [7:0]  cmd_q, cmd_d, chk_q, chk_d;
  logic [31:0] pay_q, pay_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [TW-1:0] to_q, to_d;
  logic [31:0] fword1_q, fword1_d, fword2_q, fword2_d;
  logic [11:0] pword1_q, pword1_d, pword2_q, pword2_d;
  logic [1:0]  msel1_q, msel1_d, msel2_q, msel2_d;
  logic        ok_q, ok_d, err_q, err_d;
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    chk_d   = chk_q;
    pay_d   = pay_q;
    cnt_d   = cnt_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    // Idle never times out; any received byte restarts the inter-byte window
    to_d    = (Rx_done || state_q == ST_IDLE) ? '0 : to_q + 1'b1;
    if (Rx_done) begin
      case (state_q)
        ST_IDLE: state_d = (Rx_data == HEADER) ? ST_GET_CMD : ST_IDLE;
        ST_GET_CMD: begin
          cmd_d   = Rx_data;
          chk_d   = Rx_data;
          cnt_d   = '0;
          state_d = ST_GET_DATA;
        end
        ST_GET_DATA: begin
          pay_d   = {pay_q[23:0], Rx_data};
          chk_d   = chk_q ^ Rx_data;
          cnt_d   = cnt_q + 1'b1;
          state_d = (cnt_q == 2'd3) ? ST_GET_CHK : ST_GET_DATA;
        end
        default: begin
          ok_d    = (Rx_data == chk_q) && cmd_valid(cmd_q);
          err_d   = !ok_d;
          state_d = ST_IDLE;
        end
      endcase
    end else if (state_q != ST_IDLE && to_q == TO_LAST) begin
      err_d   = 1'b1;
      state_d = ST_IDLE;
      to_d    = '0;
    end
    fword1_d = (ok_d && cmd_q == CMD_FWORD1) ? pay_q       : fword1_q;
    pword1_d = (ok_d && cmd_q == CMD_PWORD1) ? pay_q[11:0] : pword1_q;
    fword2_d = (ok_d && cmd_q == CMD_FWORD2) ? pay_q       : fword2_q;
    pword2_d = (ok_d && cmd_q == CMD_PWORD2) ? pay_q[11:0] : pword2_q;
    msel1_d  = (ok_d && cmd_q == CMD_MSEL1)  ? pay_q[1:0]  : msel1_q;
    msel2_d  = (ok_d && cmd_q == CMD_MSEL2)  ? pay_q[1:0]  : msel2_q;
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= ST_IDLE;
      cmd_q    <= '0;
      chk_q    <= '0;
      pay_q    <= '0;
      cnt_q    <= '0;
      to_q     <= '0;
      fword1_q <= FWORD_RST;
      fword2_q <= FWORD_RST;
      pword1_q <= '0;
      pword2_q <= '0;
      msel1_q  <= '0;
      msel2_q  <= '0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      chk_q    <= chk_d;
      pay_q    <= pay_d;
      cnt_q    <= cnt_d;
      to_q     <= to_d;
      fword1_q <= fword1_d;
      fword2_q <= fword2_d;
      pword1_q <= pword1_d;
      pword2_q <= pword2_d;
      msel1_q  <= msel1_d;
      msel2_q  <= msel2_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
    end
  end
  assign Fword1      = fword1_q;
  assign Pword1      = pword1_q;
  assign Fword2      = fword2_q;
  assign Pword2      = pword2_q;
  assign Module_Sel1 = msel1_q;
  assign Module_Sel2 = msel2_q;
  assign Cmd_ok      = ok_q;
  assign Cmd_err     = err_q;
endmodule

// File: tb/tb_dds_uart_cmd_parser.sv
// tb_dds_uart_cmd_parser: scoreboard bench with a frame-level reference model for the UART command parser
module tb_dds_uart_cmd_parser;
  localparam int T = 40;
  logic        Clk = 1'b0, Reset_n = 1'b0, Rx_done = 1'b0;
  logic [7:0]  Rx_data = 8'h00;
  logic [31:0] Fword1, Fword2;
  logic [11:0] Pword1, Pword2;
  logic [1:0]  Module_Sel1, Module_Sel2;
  logic        Cmd_ok, Cmd_err;
  dds_uart_cmd_parser #(.HEADER(8'hA5), .TIMEOUT_CYC(T), .FWORD_RST(32'd8589)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Rx_data(Rx_data), .Rx_done(Rx_done),
    .Fword1(Fword1), .Pword1(Pword1), .Fword2(Fword2), .Pword2(Pword2),
    .Module_Sel1(Module_Sel1), .Module_Sel2(Module_Sel2), .Cmd_ok(Cmd_ok), .Cmd_err(Cmd_err)
  );
  always #5 Clk = ~Clk;
  typedef struct {
    bit          ok;
    logic [31:0] f1, f2;
    logic [11:0] p1, p2;
    logic [1:0]  s1, s2;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int total = 0, bad = 0;
  logic [31:0] m_f1, m_f2;
  logic [11:0] m_p1, m_p2;
  logic [1:0]  m_s1, m_s2;
  logic [7:0]  fr[$];
  int idle_cnt = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, req, $time);
    end
  endtask
  function automatic void m_reset();
    m_f1 = 32'd8589; m_f2 = 32'd8589; m_p1 = '0; m_p2 = '0; m_s1 = '0; m_s2 = '0;
    fr.delete();
    idle_cnt = 0;
  endfunction
  function automatic void push(input bit ok);
    exp_t e;
    e.ok = ok; e.f1 = m_f1; e.f2 = m_f2; e.p1 = m_p1; e.p2 = m_p2; e.s1 = m_s1; e.s2 = m_s2;
    exp_q.push_back(e);
  endfunction
  function automatic void model_byte(input logic [7:0] d);
    logic [31:0] p;
    logic [7:0]  c;
    bit good;
    if (fr.size() == 0) begin
      if (d == 8'hA5) fr.push_back(d);
    end else begin
      fr.push_back(d);
      if (fr.size() == 7) begin
        c = fr[1];
        p = {fr[2], fr[3], fr[4], fr[5]};
        good = (fr[6] == (c ^ fr[2] ^ fr[3] ^ fr[4] ^ fr[5])) && c >= 8'd1 && c <= 8'd6;
        if (good) begin
          if (c == 8'd1) m_f1 = p;
          if (c == 8'd2) m_p1 = p[11:0];
          if (c == 8'd3) m_f2 = p;
          if (c == 8'd4) m_p2 = p[11:0];
          if (c == 8'd5) m_s1 = p[1:0];
          if (c == 8'd6) m_s2 = p[1:0];
        end
        push(good);
        fr.delete();
      end
    end
  endfunction
  // One clock of stimulus; the model is updated before the edge that the DUT acts on
  task automatic tick(input bit v, input logic [7:0] d);
    Rx_done = v;
    Rx_data = v ? d : 8'($urandom);
    if (v) begin
      idle_cnt = 0;
      model_byte(d);
    end else begin
      idle_cnt++;
      if (fr.size() != 0 && idle_cnt == T) begin
        fr.delete();
        push(1'b0);
      end
    end
    @(posedge Clk);
    #1;
  endtask
  task automatic idle(input int n);
    repeat (n) tick(1'b0, 8'h00);
  endtask
  task automatic send_byte(input logic [7:0] d, input int gap);
    idle(gap);
    tick(1'b1, d);
  endtask
  // pos selects a byte index that is preceded by gl idle cycles; other bytes get small random gaps
  task automatic send_frame(input logic [7:0] c, input logic [31:0] p, input logic [7:0] chkx,
                            input int pos, input int gl);
    logic [7:0] b[7];
    b[0] = 8'hA5; b[1] = c; b[2] = p[31:24]; b[3] = p[23:16]; b[4] = p[15:8]; b[5] = p[7:0];
    b[6] = (c ^ b[2] ^ b[3] ^ b[4] ^ b[5]) ^ chkx;
    for (int i = 0; i < 7; i++) send_byte(b[i], (i == pos) ? gl : int'($urandom_range(0, 1)));
  endtask
  task automatic check_regs(input string tag);
    check({tag, "_fword1"}, Fword1, m_f1);
    check({tag, "_fword2"}, Fword2, m_f2);
    check({tag, "_pword1"}, 32'(Pword1), 32'(m_p1));
    check({tag, "_pword2"}, 32'(Pword2), 32'(m_p2));
    check({tag, "_msel1"}, 32'(Module_Sel1), 32'(m_s1));
    check({tag, "_msel2"}, 32'(Module_Sel2), 32'(m_s2));
  endtask
  always @(negedge Clk) begin
    if (Reset_n && (Cmd_ok || Cmd_err)) begin
      if (Cmd_ok && Cmd_err) check("ok_err_exclusive", 32'({Cmd_ok, Cmd_err}), 32'b01);
      if (exp_q.size() == 0) check("unexpected_pulse", 32'({Cmd_ok, Cmd_err}), 32'd0);
      else begin
        mon_e = exp_q.pop_front();
        check("pulse_ok", 32'(Cmd_ok), 32'(mon_e.ok));
        check("pulse_err", 32'(Cmd_err), 32'(!mon_e.ok));
        check("sb_fword1", Fword1, mon_e.f1);
        check("sb_fword2", Fword2, mon_e.f2);
        check("sb_pword1", 32'(Pword1), 32'(mon_e.p1));
        check("sb_pword2", 32'(Pword2), 32'(mon_e.p2));
        check("sb_msel1", 32'(Module_Sel1), 32'(mon_e.s1));
        check("sb_msel2", 32'(Module_Sel2), 32'(mon_e.s2));
      end
    end
  end
  initial begin
    m_reset();
    repeat (3) @(posedge Clk);
    #1 Reset_n = 1'b1;
    check_regs("reset");
    check("reset_pulses", 32'({Cmd_ok, Cmd_err}), 32'd0);
    idle(3);
    send_frame(8'h01, 32'h051EB852, 8'h00, 0, 0);
    check("fword1_direct", Fword1, 32'h051EB852);
    send_frame(8'h04, 32'h00000800, 8'h00, 0, 0);
    send_frame(8'h04, 32'h00000C00, 8'h01, 0, 0);
    check("pword2_kept", 32'(Pword2), 32'h800);
    send_frame(8'h07, 32'h00000000, 8'h00, 0, 0);
    send_byte(8'h00, 0);
    send_byte(8'hFF, 2);
    send_frame(8'h02, 32'hFFFF0ABC, 8'h00, 0, 0);
    check("pword1_direct", 32'(Pword1), 32'hABC);
    send_byte(8'hA5, 1);
    send_byte(8'h01, 0);
    send_byte(8'h12, 0);
    idle(T + 3);
    send_frame(8'h03, 32'h12345678, 8'h00, 0, 0);
    send_frame(8'h06, 32'h00000002, 8'h00, 4, T - 1);
    check("msel2_forced_edge", 32'(Module_Sel2), 32'd2);
    send_byte(8'hA5, 0);
    send_byte(8'h05, 0);
    send_byte(8'h00, 0);
    Reset_n = 1'b0;
    #2;
    m_reset();
    check_regs("midreset");
    check("midreset_pulses", 32'({Cmd_ok, Cmd_err}), 32'd0);
    @(posedge Clk);
    #3 Reset_n = 1'b1;
    @(posedge Clk);
    #1;
    send_frame(8'h05, 32'h00000003, 8'h00, 0, 0);
    check("msel1_direct", 32'(Module_Sel1), 32'd3);
    for (int n = 0; n < 250; n++) begin
      int kind = $urandom_range(0, 9);
      logic [31:0] p = $urandom;
      if ($urandom_range(0, 3) == 0) p[15:8] = 8'hA5;
      if (kind == 0) send_byte(8'($urandom), $urandom_range(0, 3));
      else if (kind == 1) send_frame(8'($urandom_range(1, 6)), p, 8'($urandom_range(1, 255)), 0, 0);
      else if (kind == 2) send_frame(8'($urandom_range(0, 9)), p, 8'h00, 0, 0);
      else if (kind == 3) send_frame(8'($urandom_range(1, 6)), p, 8'h00, $urandom_range(1, 6),
                                     (T - 1) + int'($urandom_range(0, 1)));
      else send_frame(8'($urandom_range(1, 6)), p, 8'h00, 0, $urandom_range(0, 2));
    end
    idle(T + 5);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check_regs("final");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
